// File: rtl/conv_window_3x3_pkg.sv
// rtl/conv_window_3x3_pkg.sv - shared constants and helpers for the 3x3 window generator
package conv_window_3x3_pkg;

  localparam int KSIZE = 3;
  localparam int KAREA = KSIZE * KSIZE;

  // Window slot for row r (0 = top) and column c (0 = left)
  function automatic int slot_idx(input int r, input int c);
    return KSIZE * r + c;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_window_3x3_line_buffer_row.sv
// rtl/conv_window_3x3_line_buffer_row.sv - one row of samples, read-before-write per column
module line_buffer_row
  import conv_window_3x3_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMG_W = 28
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [cnt_w(IMG_W)-1:0]  addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [IMG_W];

  // Combinational read sees the old contents on the same cycle the new sample is written
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window_3x3.sv
// rtl/conv_window_3x3.sv - streaming 3x3 sliding-window generator, valid (no-padding) windows only
module conv_window_3x3
  import conv_window_3x3_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   din_vld,
  input  logic [WIDTH-1:0]       din,
  output logic [KAREA*WIDTH-1:0] win,
  output logic                   win_vld,
  output logic                   frame_done
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_EDGE = CW'(KSIZE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_EDGE = RW'(KSIZE - 1);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             accept;
  logic [WIDTH-1:0] lb0_q;
  logic [WIDTH-1:0] lb1_q;
  logic [WIDTH-1:0] new_col [KSIZE];
  logic [WIDTH-1:0] win_q   [KAREA];

  assign accept = ce & din_vld;

  // Incoming right-hand column, top to bottom: two rows ago, previous row, current sample
  assign new_col[0] = lb1_q;
  assign new_col[1] = lb0_q;
  assign new_col[2] = din;

  line_buffer_row #(.WIDTH(WIDTH), .IMG_W(IMG_W)) lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (din),
    .rdata (lb0_q)
  );

  line_buffer_row #(.WIDTH(WIDTH), .IMG_W(IMG_W)) lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (lb0_q),
    .rdata (lb1_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      win_vld    <= 1'b0;
      frame_done <= 1'b0;
      for (int k = 0; k < KAREA; k++) win_q[k] <= '0;
    end else begin
      win_vld    <= accept && (row >= ROW_EDGE) && (col >= COL_EDGE);
      frame_done <= accept && (row == ROW_LAST) && (col == COL_LAST);
      if (accept) begin
        for (int r = 0; r < KSIZE; r++) begin
          for (int c = 0; c < KSIZE - 1; c++) begin
            win_q[slot_idx(r, c)] <= win_q[slot_idx(r, c + 1)];
          end
          win_q[slot_idx(r, KSIZE - 1)] <= new_col[r];
        end
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < KAREA; k++) begin : g_flat
    assign win[WIDTH*k +: WIDTH] = win_q[k];
  end

endmodule

// File: tb/tb_conv_window_3x3.sv
// tb/tb_conv_window_3x3.sv - self-checking bench for conv_window_3x3
module tb_conv_window_3x3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        din_vld = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [71:0] win;
  logic        win_vld;
  logic        frame_done;

  logic        ce4 = 1'b0;
  logic        vld4 = 1'b0;
  logic [7:0]  din4 = 8'h00;
  logic [71:0] win4;
  logic        wv4;
  logic        fd4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conv_window_3x3 dut (
    .clk(clk), .rst(rst), .ce(ce), .din_vld(din_vld), .din(din),
    .win(win), .win_vld(win_vld), .frame_done(frame_done)
  );

  conv_window_3x3 #(.WIDTH(8), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst(rst), .ce(ce4), .din_vld(vld4), .din(din4),
    .win(win4), .win_vld(wv4), .frame_done(fd4)
  );

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_win(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] mk9(input int s0, input int s1, input int s2,
                                      input int s3, input int s4, input int s5,
                                      input int s6, input int s7, input int s8);
    logic [71:0] v;
    v = {8'(s8), 8'(s7), 8'(s6), 8'(s5), 8'(s4), 8'(s3), 8'(s2), 8'(s1), 8'(s0)};
    return v;
  endfunction

  // Reference model: the frame as an image, windows cut straight from it
  logic [7:0]  img [28][28];
  int          mr = 0;
  int          mc = 0;
  bit          pend_vld;
  bit          pend_fd;
  bit          acc;
  bit          last_emit = 1'b0;
  logic [71:0] exp_win;
  logic [71:0] last_win;
  logic [71:0] first_win;
  logic [71:0] last_fd_win;
  bit          arm_first = 1'b0;
  int          cyc = 0;
  int          last_vld_cyc = -1000;
  int          dut_win_cnt = 0;
  int          dut_fd_cnt = 0;
  int          gap3_cnt = 0;
  int          gap9_cnt = 0;

  always @(posedge clk) begin
    cyc++;
    acc = rst && ce && din_vld;
    pend_vld = 1'b0;
    pend_fd = 1'b0;
    if (!rst) begin
      mr = 0;
      mc = 0;
      last_emit = 1'b0;
    end else if (acc) begin
      img[mr][mc] = din;
      if (mr >= 2 && mc >= 2) begin
        pend_vld = 1'b1;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp_win[8*(3*r+c) +: 8] = img[mr-2+r][mc-2+c];
        last_win = exp_win;
      end
      pend_fd = (mr == 27 && mc == 27);
      last_emit = pend_vld;
      mc++;
      if (mc == 28) begin
        mc = 0;
        mr = (mr == 27) ? 0 : mr + 1;
      end
    end
    #1;
    chk_int("win_vld", int'(win_vld), int'(pend_vld));
    chk_int("frame_done", int'(frame_done), int'(pend_fd));
    if (pend_vld) chk_win("win", win, exp_win);
    else if (rst && !acc && last_emit) chk_win("win_hold", win, last_win);
    if (win_vld) begin
      dut_win_cnt++;
      if (cyc - last_vld_cyc == 3) gap3_cnt++;
      else if (cyc - last_vld_cyc == 9) gap9_cnt++;
      last_vld_cyc = cyc;
      if (arm_first) begin
        first_win = win;
        arm_first = 1'b0;
      end
    end
    if (frame_done) begin
      dut_fd_cnt++;
      last_fd_win = win;
    end
  end

  // mode 0: continuous, 1: random idle gaps, 2: one sample every 3rd cycle
  task automatic send_frame(input int base, input int mode, input int freeze_at, input int stop_after);
    int n;
    n = 0;
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++) begin
        if (n == stop_after) return;
        if (n == freeze_at) begin
          repeat (5) begin
            @(negedge clk);
            ce = 1'b0; din_vld = 1'b1; din = 8'hEE;
          end
        end
        if (mode == 1) begin
          repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            ce = 1'b1; din_vld = 1'b0;
          end
        end
        if (mode == 2) begin
          repeat (2) begin
            @(negedge clk);
            ce = 1'b1; din_vld = 1'b0;
          end
        end
        @(negedge clk);
        ce = 1'b1; din_vld = 1'b1; din = 8'((r*28 + c + base) & 255);
        n++;
      end
    end
    @(negedge clk);
    din_vld = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int          p_idx[$];
  logic [71:0] p_win[$];
  int          fd4_idx;
  int          fd4_cnt;
  int          w0, f0, g3, g9;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_win("reset_win", win, 72'h0);
    chk_int("reset_win_vld", int'(win_vld), 0);
    chk_int("reset_frame_done", int'(frame_done), 0);
    chk_win("reset_win4", win4, 72'h0);
    @(negedge clk);
    rst = 1'b1;

    // 4x4 frame, samples 0..15
    fd4_idx = -1;
    fd4_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      ce4 = 1'b1; vld4 = (i < 16); din4 = 8'(i);
      @(posedge clk);
      #1;
      if (wv4) begin
        p_idx.push_back(i);
        p_win.push_back(win4);
      end
      if (fd4) begin
        fd4_cnt++;
        fd4_idx = i;
      end
    end
    @(negedge clk);
    vld4 = 1'b0;
    chk_int("t1_pulses", p_idx.size(), 4);
    chk_int("t1_fd_count", fd4_cnt, 1);
    chk_int("t1_fd_at", fd4_idx, 15);
    if (p_idx.size() == 4) begin
      chk_int("t1_first_at", p_idx[0], 10);
      chk_win("t1_win0", p_win[0], mk9(0, 1, 2, 4, 5, 6, 8, 9, 10));
      chk_win("t1_win1", p_win[1], mk9(1, 2, 3, 5, 6, 7, 9, 10, 11));
      chk_win("t1_win3", p_win[3], mk9(5, 6, 7, 9, 10, 11, 13, 14, 15));
    end

    // Full frame with random input gaps
    w0 = dut_win_cnt; f0 = dut_fd_cnt;
    arm_first = 1'b1;
    send_frame(0, 1, -1, -1);
    chk_int("t2_windows", dut_win_cnt - w0, 676);
    chk_int("t2_frame_done", dut_fd_cnt - f0, 1);
    chk_win("t2_first_win", first_win, mk9(0, 1, 2, 28, 29, 30, 56, 57, 58));
    chk_win("t2_last_win", last_fd_win, mk9(213, 214, 215, 241, 242, 243, 13, 14, 15));

    // ce held low for 5 cycles mid-row
    w0 = dut_win_cnt; f0 = dut_fd_cnt;
    send_frame(0, 0, 5*28 + 10, -1);
    chk_int("t3_windows", dut_win_cnt - w0, 676);
    chk_int("t3_frame_done", dut_fd_cnt - f0, 1);

    // Two frames back to back, second offset by 100
    w0 = dut_win_cnt; f0 = dut_fd_cnt;
    send_frame(0, 0, -1, -1);
    send_frame(100, 0, -1, -1);
    chk_int("t4_windows", dut_win_cnt - w0, 1352);
    chk_int("t4_frame_done", dut_fd_cnt - f0, 2);
    chk_win("t4_last_win", last_fd_win, mk9(57, 58, 59, 85, 86, 87, 113, 114, 115));

    // Asynchronous reset after the 40th sample
    send_frame(0, 0, -1, 40);
    @(negedge clk);
    din_vld = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_win("t5_async_win", win, 72'h0);
    chk_int("t5_async_vld", int'(win_vld), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    w0 = dut_win_cnt; f0 = dut_fd_cnt;
    send_frame(0, 0, -1, -1);
    chk_int("t5_windows", dut_win_cnt - w0, 676);
    chk_int("t5_frame_done", dut_fd_cnt - f0, 1);
    chk_win("t5_last_win", last_fd_win, mk9(213, 214, 215, 241, 242, 243, 13, 14, 15));

    // One sample every 3rd cycle
    w0 = dut_win_cnt; g3 = gap3_cnt; g9 = gap9_cnt;
    send_frame(0, 2, -1, -1);
    chk_int("t6_windows", dut_win_cnt - w0, 676);
    chk_int("t6_gap3", gap3_cnt - g3, 650);
    chk_int("t6_gap9", gap9_cnt - g9, 25);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
